layer_collector: RTL and testbench
==================================

LAYER_COLLECTOR -- requirements
Module: layer_collector

Interface
REQ-001 Parameter SIZE, default 3, number of serial samples (neurons) per frame; SHALL be >= 2.
REQ-002 Parameter BIT_SIZE, default 1, width of each sample in bits.
REQ-003 clk  input  1  clock; all state SHALL update on posedge clk.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 y_in  input  BIT_SIZE  serial activated neuron output from the upstream layer, one sample per cycle.
REQ-006 frame_start  input  1  high in the same cycle as sample 0 of a frame.
REQ-007 out_vec  output  SIZE x BIT_SIZE  collected frame; element i = i-th received sample.
REQ-008 out_valid  output  1  out_vec holds an unconsumed frame.
REQ-009 out_ready  input  1  consumer accepts out_vec when out_valid && out_ready at posedge.
REQ-010 overrun  output  1  sticky: a completed frame was dropped because the output was still occupied.
REQ-011 restart_err  output  1  sticky: frame_start arrived mid-frame.
REQ-012 argmax_idx  output  clog2(SIZE)  index of the largest element of out_vec; present only with LAYER_COLLECTOR_ARGMAX_EN.

Function
REQ-013 FSM states SHALL be IDLE and COLLECT; the sample counter cnt SHALL be clog2(SIZE)+1 bits wide.
REQ-014 IDLE, frame_start=1: capture y_in into collect buffer slot 0, cnt<=1, go to COLLECT.
REQ-015 IDLE, frame_start=0: y_in ignored; state unchanged.
REQ-016 COLLECT, frame_start=0: capture y_in into slot cnt, cnt<=cnt+1, one sample per cycle, no gaps.
REQ-017 COLLECT, sample at cnt==SIZE-1 with frame_start=0: frame complete; go to IDLE; cnt<=0.
REQ-018 COLLECT, frame_start=1: abort current frame, capture y_in into slot 0, cnt<=1, stay in COLLECT, set restart_err.
REQ-019 On frame complete, if out_valid==0 or out_ready==1 in that cycle: out_vec<=full frame (including the sample of that cycle) and out_valid<=1 on the next edge; latency 1 cycle from last sample to out_valid.
REQ-020 On frame complete with out_valid==1 and out_ready==0: frame dropped, out_vec unchanged, overrun<=1.
REQ-021 out_valid && out_ready without a simultaneous frame completion: out_valid<=0 next edge.
REQ-022 Simultaneous accept and completion: out_valid SHALL stay 1 and out_vec SHALL take the new frame (back-to-back, no bubble).
REQ-023 out_vec SHALL remain stable while out_valid==1 && out_ready==0.
REQ-024 Sustained throughput: one frame per SIZE cycles with out_ready held high, no drops.
REQ-025 overrun and restart_err SHALL clear only on rst.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, cnt=0, collect buffer=0, out_vec=0, out_valid=0, overrun=0, restart_err=0, argmax_idx=0.
REQ-027 rst mid-frame SHALL discard the partial frame; the first frame_start after release starts a fresh frame.
REQ-028 After rst deasserts, no output SHALL change until the first frame_start.

Configuration
REQ-029 Macro LAYER_COLLECTOR_ARGMAX_EN, when defined: argmax_idx port exists, is registered together with out_vec in the same cycle, compares elements as unsigned, and on ties reports the lowest index.
REQ-030 Macro undefined: argmax_idx port and compare logic SHALL be absent; all other behaviour identical.

Verification (SIZE=3, BIT_SIZE=4)
REQ-031 frame_start at cycle 0, y_in=5,9,2 on cycles 0..2, out_ready=1 -> cycle 3 out_vec={5,9,2}, out_valid=1, argmax_idx=1 (macro on).
REQ-032 Two back-to-back frames {1,2,3},{7,7,0}, out_ready=1 -> out_valid high continuously from cycle 3; out_vec={7,7,0} at cycle 6; argmax_idx=0 (tie).
REQ-033 out_ready=0, two frames {4,4,4},{8,0,0} -> out_vec stays {4,4,4}; overrun=1 at cycle 6; second frame lost.
REQ-034 frame_start at cycle 0 and again at cycle 1, then y_in=3,6 -> restart_err=1; out_vec={y@1,3,6} at cycle 4.
REQ-035 rst pulsed at cycle 1 of a frame -> all outputs 0; next full frame {2,0,1} collected correctly, overrun=0.

Source files
------------

// File: rtl/layer_collector.sv
`default_nettype none
// ============================================================================
// Module      : layer_collector
// Description : Gathers SIZE serial neuron samples into one parallel frame
//               and presents it on a valid/ready output register. Sticky
//               flags record dropped frames (overrun) and frames restarted
//               part-way through (restart_err).
//               Optional feature macro LAYER_COLLECTOR_ARGMAX_EN adds a
//               registered argmax_idx output (unsigned compare, lowest
//               index wins on ties).
// Revision    : 1.0 - initial release
// ============================================================================
module layer_collector #(
    parameter int SIZE     = 3,
    parameter int BIT_SIZE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BIT_SIZE-1:0]      y_in,
    input  logic                     frame_start,
    output logic [SIZE*BIT_SIZE-1:0] out_vec,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overrun,
    output logic                     restart_err
`ifdef LAYER_COLLECTOR_ARGMAX_EN
    ,
    output logic [$clog2(SIZE)-1:0]  argmax_idx
`endif
);

    localparam int c_CNT_W = $clog2(SIZE) + 1;
    localparam int c_IDX_W = $clog2(SIZE);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SIZE - 1);
    localparam logic [c_CNT_W-1:0] c_ONE  = c_CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_next;
    logic                 w_capture;
    logic [c_CNT_W-1:0]   w_slot;
    logic                 w_complete;
    logic                 w_restart;
    logic                 w_load;
    logic                 w_drop;
    logic [SIZE*BIT_SIZE-1:0] w_frame;

    // The last sample of a frame goes straight into out_vec, so the
    // collect buffer only needs to hold slots 0..SIZE-2.
    logic [BIT_SIZE-1:0]  r_buf [SIZE-1];

    // State and sample-counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state and capture control; a frame_start always wins and
    // restarts the frame at slot 0
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        w_slot       = '0;
        w_complete   = 1'b0;
        w_restart    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (frame_start) begin
                    w_capture    = 1'b1;
                    w_slot       = '0;
                    w_cnt_next   = c_ONE;
                    w_state_next = S_COLLECT;
                end
            end
            S_COLLECT: begin
                w_capture = 1'b1;
                if (frame_start) begin
                    w_slot     = '0;
                    w_cnt_next = c_ONE;
                    w_restart  = 1'b1;
                end else begin
                    w_slot = r_cnt;
                    if (r_cnt == c_LAST) begin
                        w_complete   = 1'b1;
                        w_cnt_next   = '0;
                        w_state_next = S_IDLE;
                    end else begin
                        w_cnt_next = r_cnt + c_ONE;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // A completed frame is taken if the output slot is free or being
    // emptied this very cycle; otherwise it is dropped
    assign w_load = w_complete && (!out_valid || out_ready);
    assign w_drop = w_complete && out_valid && !out_ready;

    // Per-slot collect buffer and assembly of the outgoing frame
    generate
        for (genvar gi = 0; gi < SIZE - 1; gi++) begin : g_slot
            // Store the sample addressed to this slot
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_buf[gi] <= '0;
                end else if (w_capture && (w_slot == c_CNT_W'(gi))) begin
                    r_buf[gi] <= y_in;
                end
            end
            assign w_frame[gi*BIT_SIZE +: BIT_SIZE] = r_buf[gi];
        end
    endgenerate

    assign w_frame[(SIZE-1)*BIT_SIZE +: BIT_SIZE] = y_in;

    // Output register, valid handshake and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vec     <= '0;
            out_valid   <= 1'b0;
            overrun     <= 1'b0;
            restart_err <= 1'b0;
        end else begin
            if (w_load) begin
                out_vec   <= w_frame;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (w_drop) begin
                overrun <= 1'b1;
            end
            if (w_restart) begin
                restart_err <= 1'b1;
            end
        end
    end

`ifdef LAYER_COLLECTOR_ARGMAX_EN
    logic [c_IDX_W-1:0]  w_argmax;
    logic [BIT_SIZE-1:0] w_max;

    // Unsigned running maximum; strict greater-than keeps the lowest index on ties
    always_comb begin
        w_argmax = '0;
        w_max    = w_frame[BIT_SIZE-1:0];
        for (int i = 1; i < SIZE; i++) begin
            if (w_frame[i*BIT_SIZE +: BIT_SIZE] > w_max) begin
                w_max    = w_frame[i*BIT_SIZE +: BIT_SIZE];
                w_argmax = c_IDX_W'(i);
            end
        end
    end

    // Argmax is registered in the same cycle as out_vec
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            argmax_idx <= '0;
        end else if (w_load) begin
            argmax_idx <= w_argmax;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_layer_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_collector
// Description : Scoreboard bench for layer_collector (SIZE=3, BIT_SIZE=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_collector;

    localparam int c_SIZE = 3;
    localparam int c_BW   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [c_BW-1:0]   y_in = '0;
    logic              frame_start = 1'b0;
    logic              out_ready = 1'b0;
    logic [c_SIZE*c_BW-1:0] out_vec;
    logic              out_valid;
    logic              overrun;
    logic              restart_err;
    logic [1:0]        argmax_idx_w;

    typedef struct {
        logic [c_SIZE*c_BW-1:0] vec;
        logic [1:0]             idx;
    } exp_t;

    exp_t exp_q[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int               m_cnt = 0;
    logic [c_BW-1:0]  m_fr [c_SIZE];
    bit               m_valid = 1'b0;
    bit               m_over = 1'b0;
    bit               m_rerr = 1'b0;
    logic [c_SIZE*c_BW-1:0] m_last = '0;
    logic [1:0]       m_idx = '0;
    bit               m_done;
    exp_t             m_e;

    layer_collector #(
        .SIZE     (c_SIZE),
        .BIT_SIZE (c_BW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .y_in        (y_in),
        .frame_start (frame_start),
        .out_vec     (out_vec),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .overrun     (overrun),
        .restart_err (restart_err)
`ifdef LAYER_COLLECTOR_ARGMAX_EN
        ,
        .argmax_idx  (argmax_idx_w)
`endif
    );

`ifndef LAYER_COLLECTOR_ARGMAX_EN
    assign argmax_idx_w = 2'd0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] amax(input logic [c_BW-1:0] a, input logic [c_BW-1:0] b,
                                        input logic [c_BW-1:0] c);
        logic [1:0] k;
        logic [c_BW-1:0] m;
        k = 2'd0; m = a;
        if (b > m) begin k = 2'd1; m = b; end
        if (c > m) begin k = 2'd2; end
        return k;
    endfunction

    // Reference model: assembles frames and predicts the output handshake
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cnt = 0; m_valid = 1'b0; m_over = 1'b0; m_rerr = 1'b0;
            m_last = '0; m_idx = '0;
            exp_q.delete();
        end else begin
            m_done = 1'b0;
            if (frame_start) begin
                if (m_cnt != 0) m_rerr = 1'b1;
                m_fr[0] = y_in;
                m_cnt = 1;
            end else if (m_cnt != 0) begin
                m_fr[m_cnt] = y_in;
                if (m_cnt == c_SIZE - 1) begin
                    m_done = 1'b1;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
            if (m_done) begin
                if (!m_valid || out_ready) begin
                    m_last  = {m_fr[2], m_fr[1], m_fr[0]};
                    m_idx   = amax(m_fr[0], m_fr[1], m_fr[2]);
                    m_e.vec = m_last;
                    m_e.idx = m_idx;
                    exp_q.push_back(m_e);
                    m_valid = 1'b1;
                end else begin
                    m_over = 1'b1;
                end
            end else if (m_valid && out_ready) begin
                m_valid = 1'b0;
            end
        end
    end

    // Compare outputs mid-cycle; pop the scoreboard when a frame is consumed
    always @(negedge clk) begin
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_vec", {20'd0, out_vec}, {20'd0, m_last});
        check("overrun", {31'd0, overrun}, {31'd0, m_over});
        check("restart_err", {31'd0, restart_err}, {31'd0, m_rerr});
`ifdef LAYER_COLLECTOR_ARGMAX_EN
        check("argmax_idx", {30'd0, argmax_idx_w}, {30'd0, m_idx});
`endif
        if (!rst && m_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_depth", 32'(exp_q.size()), 32'd1);
            end else begin
                m_e = exp_q.pop_front();
                check("sb_vec", {20'd0, out_vec}, {20'd0, m_e.vec});
`ifdef LAYER_COLLECTOR_ARGMAX_EN
                check("sb_idx", {30'd0, argmax_idx_w}, {30'd0, m_e.idx});
`endif
            end
        end
    end

    // One cycle of stimulus, applied just after the rising edge
    task automatic drive(input logic fs, input logic [c_BW-1:0] y, input logic rdy);
        @(posedge clk);
        #1;
        frame_start = fs;
        y_in        = y;
        out_ready   = rdy;
    endtask

    task automatic frame(input logic [c_BW-1:0] a, input logic [c_BW-1:0] b,
                         input logic [c_BW-1:0] c, input logic rdy);
        drive(1'b1, a, rdy);
        drive(1'b0, b, rdy);
        drive(1'b0, c, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 4'($urandom_range(0, 15)), rdy);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(3, 1'b1);

        // Single frame, max in the middle
        frame(4'd5, 4'd9, 4'd2, 1'b1);
        idle(3, 1'b1);

        // Back-to-back frames, second with a tie
        frame(4'd1, 4'd2, 4'd3, 1'b1);
        frame(4'd7, 4'd7, 4'd0, 1'b1);
        idle(3, 1'b1);

        // Consumer stalled: second frame dropped, first held stable
        frame(4'd4, 4'd4, 4'd4, 1'b0);
        frame(4'd8, 4'd0, 4'd0, 1'b0);
        idle(3, 1'b0);
        idle(3, 1'b1);

        // Restart mid-frame
        drive(1'b1, 4'd10, 1'b1);
        drive(1'b1, 4'd11, 1'b1);
        drive(1'b0, 4'd3, 1'b1);
        drive(1'b0, 4'd6, 1'b1);
        idle(3, 1'b1);

        // Reset in the middle of a frame, then a clean frame
        drive(1'b1, 4'd9, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2, 1'b1);
        frame(4'd2, 4'd0, 4'd1, 1'b1);
        idle(3, 1'b1);

        // Random frames, random gaps, random consumer stalls and restarts
        for (int f = 0; f < 25; f++) begin
            drive(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            for (int s = 1; s < c_SIZE; s++) begin
                drive(($urandom_range(0, 19) == 0), 4'($urandom_range(0, 15)),
                      1'($urandom_range(0, 1)));
            end
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
        end

        // Drain
        idle(5, 1'b1);
        @(negedge clk);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
